// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window reader.
package conv_pkg;

   localparam int WIN_K = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Flat element index of window row r, column c.
   function automatic int win_idx(input int r, input int c);
      return r * WIN_K + c;
   endfunction

endpackage

// File: rtl/conv_col_skid.sv
// One-entry column skid: zero-latency pass-through when out_rdy_i is high, otherwise parks the column.
// in_rdy_o drops while a column is parked and rises again once it has been taken.
module conv_col_skid #(
   parameter int WIDTH = 96
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld_i,
   input  logic [WIDTH-1:0] in_dat_i,
   output logic             in_rdy_o,
   output logic             out_vld_o,
   output logic [WIDTH-1:0] out_dat_o,
   input  logic             out_rdy_i
);

   logic             full_q;
   logic [WIDTH-1:0] dat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         dat_q  <= '0;
      end else if (in_vld_i && !full_q && !out_rdy_i) begin
         full_q <= 1'b1;
         dat_q  <= in_dat_i;
      end else if (full_q && out_rdy_i) begin
         full_q <= 1'b0;
      end
   end

   assign in_rdy_o  = !full_q;
   assign out_vld_o = full_q || in_vld_i;
   assign out_dat_o = full_q ? dat_q : in_dat_i;

endmodule

// File: rtl/conv_window_reader.sv
// Sweeps one read pass over the 3-row line buffer and streams 3x3 windows; reads land 1 cycle after r_en.
// A stalled output parks one column in the skid and halts reads; CONV_WINDOW_ZERO_PAD_EN adds same-size zero padding.
module conv_window_reader
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ROWS          = 3,
   parameter int MAX_ROW_WIDTH = 1024,
   parameter int ADDR_WIDTH    = $clog2(MAX_ROW_WIDTH)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [ADDR_WIDTH-1:0]               row_width,
   input  logic                                full,
   input  logic [ROWS*DATA_WIDTH-1:0]          rows_in,
   output logic                                r_en,
   output logic [ADDR_WIDTH-1:0]               r_add,
   output logic [WIN_K*WIN_K*DATA_WIDTH-1:0]   win_data,
   output logic                                win_valid,
   input  logic                                win_ready,
   output logic                                win_last,
   output logic                                busy
);

   localparam int CW = ROWS * DATA_WIDTH;
   localparam int WW = WIN_K * WIN_K * DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rw_q, rd_ptr_q, rt_ptr_q, last_add_q;
   logic                  ret_vld_q, pad_pend_q, win_valid_q, win_last_q;
   logic [WW-1:0]         win_q, win_d;
   logic [CW-1:0]         skid_dat, col;
   logic                  out_free, skid_empty, skid_vld, start;
   logic                  shift_real, shift_pad, shift, emit, last;

   assign out_free = !win_valid_q || win_ready;
   assign start    = (state_q == IDLE) && full;

   conv_col_skid #(.WIDTH(CW)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_vld_i  (ret_vld_q),
      .in_dat_i  (rows_in),
      .in_rdy_o  (skid_empty),
      .out_vld_o (skid_vld),
      .out_dat_o (skid_dat),
      .out_rdy_i (out_free)
   );

   assign shift_real = skid_vld && out_free;
   assign shift_pad  = pad_pend_q && out_free && !skid_vld;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (full) state_d = READ;
         READ:    if (r_en && rd_ptr_q == rw_q - ONE) state_d = DRAIN;
         DRAIN:   if (rt_ptr_q == rw_q && !pad_pend_q && out_free) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      r_en  = (state_q == READ) && skid_empty && out_free && !rst;
      r_add = r_en ? rd_ptr_q : last_add_q;
      busy  = (state_q != IDLE);
   end

   // rt_ptr_q is the index of the real column being shifted in.
   always_comb begin
      col   = '0;
      shift = 1'b0;
      emit  = 1'b0;
      last  = 1'b0;
      if (shift_real) begin
         col   = skid_dat;
         shift = 1'b1;
`ifdef CONV_WINDOW_ZERO_PAD_EN
         emit  = (rt_ptr_q != '0);
`else
         emit  = (rt_ptr_q >= TWO);
         last  = (rt_ptr_q == rw_q - ONE);
`endif
      end else if (shift_pad) begin
         shift = 1'b1;
         emit  = 1'b1;
         last  = 1'b1;
      end
   end

   always_comb begin
      win_d = win_q;
      for (int r = 0; r < WIN_K; r++) begin
         for (int c = 0; c < WIN_K - 1; c++) begin
            win_d[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_q[win_idx(r, c + 1)*DATA_WIDTH +: DATA_WIDTH];
         end
         win_d[win_idx(r, WIN_K - 1)*DATA_WIDTH +: DATA_WIDTH] = col[r*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rw_q        <= '0;
         rd_ptr_q    <= '0;
         rt_ptr_q    <= '0;
         last_add_q  <= '0;
         ret_vld_q   <= 1'b0;
         pad_pend_q  <= 1'b0;
         win_q       <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
      end else begin
         ret_vld_q <= r_en;
         if (r_en) begin
            rd_ptr_q   <= rd_ptr_q + ONE;
            last_add_q <= rd_ptr_q;
         end
         // Clearing the window at sweep start keeps old columns out and doubles as the leading pad column.
         if (start) begin
            rw_q       <= (row_width == '0) ? ONE : row_width;
            rd_ptr_q   <= '0;
            rt_ptr_q   <= '0;
            pad_pend_q <= 1'b0;
            win_q      <= '0;
         end else begin
            if (shift_real) rt_ptr_q <= rt_ptr_q + ONE;
`ifdef CONV_WINDOW_ZERO_PAD_EN
            if (shift_real && rt_ptr_q == rw_q - ONE) pad_pend_q <= 1'b1;
            else if (shift_pad)                        pad_pend_q <= 1'b0;
`endif
            if (shift) win_q <= win_d;
         end
         if (out_free) begin
            win_valid_q <= emit;
            win_last_q  <= emit && last;
         end
      end
   end

   assign win_data  = win_q;
   assign win_valid = win_valid_q;
   assign win_last  = win_last_q;

endmodule

// File: tb/tb_conv_window_reader.sv
// Scoreboard bench for conv_window_reader: stimulus pushes expected windows, a negedge monitor checks them.
module tb_conv_window_reader;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int CW = 3 * DW;
   localparam int WW = 9 * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] row_width;
   logic          full;
   logic [CW-1:0] rows_in = '0;
   logic          r_en;
   logic [AW-1:0] r_add;
   logic [WW-1:0] win_data;
   logic          win_valid;
   logic          win_ready;
   logic          win_last;
   logic          busy;

   int checks   = 0;
   int errors   = 0;
   int rd_count = 0;
   int exp_addr = 0;

   typedef struct {
      logic [WW-1:0] dat;
      logic          last;
   } exp_t;
   exp_t sb[$];

   conv_window_reader dut (
      .clk       (clk),
      .rst       (rst),
      .row_width (row_width),
      .full      (full),
      .rows_in   (rows_in),
      .r_en      (r_en),
      .r_add     (r_add),
      .win_data  (win_data),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_last  (win_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Buffered rows hold 1.., 11.., 21.. ; one cycle read latency.
   function automatic logic [DW-1:0] mem(input int r, input int a);
      return DW'(r * 10 + a + 1);
   endfunction

   always @(posedge clk) begin
      if (r_en) rows_in <= {mem(2, int'(r_add)), mem(1, int'(r_add)), mem(0, int'(r_add))};
   end

   function automatic logic [DW-1:0] pix(input int r, input int c, input int rw);
      if (c < 0 || c >= rw) return '0;
      return mem(r, c);
   endfunction

   function automatic int n_win(input int rw);
`ifdef CONV_WINDOW_ZERO_PAD_EN
      return rw;
`else
      return (rw >= 3) ? rw - 2 : 0;
`endif
   endfunction

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_expected(input int rw);
      int   rwe, n, c0;
      exp_t e;
      rwe = (rw == 0) ? 1 : rw;
      n   = n_win(rwe);
      for (int w = 0; w < n; w++) begin
`ifdef CONV_WINDOW_ZERO_PAD_EN
         c0 = w - 1;
`else
         c0 = w;
`endif
         e.dat = '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               e.dat[(r*3+c)*DW +: DW] = pix(r, c0 + c, rwe);
         e.last = (w == n - 1);
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (rst || !busy) exp_addr = 0;
      if (!rst) begin
         if (r_en) begin
            check("r_add", WW'(r_add), WW'(exp_addr));
            exp_addr++;
            rd_count++;
         end
         if (win_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window: got %0h expected none", win_data);
            end else begin
               check("win_data", win_data, sb[0].dat);
               check("win_last", WW'(win_last), WW'(sb[0].last));
               if (!win_ready) check("r_en_stall", WW'(r_en), '0);
               else            void'(sb.pop_front());
            end
         end
      end
   end

   task automatic start_sweep(input int rw);
      rd_count  = 0;
      row_width = AW'(rw);
      full      = 1'b1;
      @(posedge clk); #1;
      full = 1'b0;
      check("busy_start", WW'(busy), WW'(1));
   endtask

   task automatic wait_done(input int reads, input bit stall);
      int oc;
      bit done;
      oc   = 0;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (win_valid || oc > 0) oc++;
         win_ready = !(stall && oc >= 2 && oc <= 6);
         if (!busy) begin
            done = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      win_ready = 1'b1;
      check("sweep_done", WW'(done), WW'(1));
      check("reads", WW'(rd_count), WW'(reads));
      check("windows_left", WW'(sb.size()), '0);
   endtask

   task automatic run_sweep(input int rw, input bit stall);
      push_expected(rw);
      start_sweep(rw);
      wait_done((rw == 0) ? 1 : rw, stall);
   endtask

   initial begin
      int  n;
      bit  hit;
      rst       = 1'b1;
      full      = 1'b0;
      win_ready = 1'b1;
      row_width = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_r_en", WW'(r_en), '0);
      check("rst_r_add", WW'(r_add), '0);
      check("rst_win_valid", WW'(win_valid), '0);
      check("rst_win_last", WW'(win_last), '0);
      check("rst_busy", WW'(busy), '0);
      check("rst_win_data", win_data, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_sweep(5, 1'b0);
      run_sweep(5, 1'b1);
      run_sweep(8, 1'b1);
      run_sweep(3, 1'b0);
      run_sweep(2, 1'b0);
      run_sweep(0, 1'b0);
`ifdef CONV_WINDOW_ZERO_PAD_EN
      run_sweep(4, 1'b0);
      run_sweep(1, 1'b0);
`endif

      // Abort on the second window, then restart from full held high.
      push_expected(5);
      n = n_win(5);
      start_sweep(5);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (win_valid && sb.size() == n - 1) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("second_window_seen", WW'(hit), WW'(1));
      rst  = 1'b1;
      full = 1'b1;
      @(posedge clk); #1;
      check("abort_win_valid", WW'(win_valid), '0);
      check("abort_r_en", WW'(r_en), '0);
      check("abort_busy", WW'(busy), '0);
      sb.delete();
      push_expected(5);
      rd_count = 0;
      rst = 1'b0;
      @(posedge clk); #1;
      full = 1'b0;
      check("restart_busy", WW'(busy), WW'(1));
      check("restart_r_en", WW'(r_en), WW'(1));
      check("restart_r_add", WW'(r_add), '0);
      wait_done(5, 1'b0);

      // Back-to-back sweeps with full held high.
      push_expected(5);
      push_expected(5);
      rd_count  = 0;
      row_width = AW'(5);
      full      = 1'b1;
      @(posedge clk); #1;
      check("b2b_busy", WW'(busy), WW'(1));
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("b2b_first_done", WW'(hit), WW'(1));
      @(posedge clk); #1;
      full = 1'b0;
      check("b2b_restart", WW'(busy), WW'(1));
      wait_done(10, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Sits directly downstream of the 3-row BRAM line buffer. Waits for the buffer's full flag, then sweeps one read pass across the buffered rows.
- Builds 3x3 pixel windows in a column shift register and streams them to the convolution MAC array over a valid/ready handshake.
- The sweep's final read (r_add = row_width-1) releases the oldest row back to the buffer.

Parameters:
- DATA_WIDTH, 32, pixel width.
- ROWS, 3, rows per window; fixed at 3 for this block.
- MAX_ROW_WIDTH, 1024, maximum pixels per row.
- ADDR_WIDTH, $clog2(MAX_ROW_WIDTH), width of address and row-width fields.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- row_width  in  ADDR_WIDTH  pixels per row; sampled at sweep start.
- full  in  1  line buffer holds ROWS complete rows.
- rows_in  in  ROWS*DATA_WIDTH  line buffer read data; slice 0 = oldest row; valid 1 cycle after r_en.
- r_en  out  1  line buffer read enable.
- r_add  out  ADDR_WIDTH  line buffer read address.
- win_data  out  9*DATA_WIDTH  window; element (r,c) at [(r*3+c)*DATA_WIDTH +: DATA_WIDTH]; r0 = oldest row, c0 = leftmost column.
- win_valid  out  1  win_data valid.
- win_ready  in  1  consumer accepts window.
- win_last  out  1  with win_valid: last window of the row.
- busy  out  1  sweep in progress.

Behaviour:
- Reset values: r_en=0, r_add=0, win_valid=0, win_last=0, busy=0, win_data=0. State=IDLE; all counters and the skid register cleared.
- rst mid-sweep aborts the sweep immediately. No further reads are issued. The line buffer row is not released; the upstream block must be reset together with this one.
- FSM states:
  - IDLE: on full=1, latch row_width into rw_q, clear counters, go to READ.
  - READ: issue reads. After issuing addr rw_q-1, go to DRAIN.
  - DRAIN: wait for the last column to return and the output to empty (win_valid=0 or accepted), then go to IDLE. busy=0 in IDLE only.
- Read issue (READ state): r_en=1 with r_add=rd_ptr only when the skid register is empty AND NOT (win_valid AND NOT win_ready). rd_ptr then increments. Otherwise r_en=0 and r_add holds.
- Read latency is 1 cycle: a column issued at cycle t is presented on rows_in at t+1 and tagged with rt_ptr.
- Returned column handling:
  - If the output stage is free, shift the column into the window: c0<=c1, c1<=c2, c2<=new. Increment rt_ptr.
  - Otherwise capture the column in a 1-entry skid register. It is shifted in on the cycle the output frees.
- Window emit: after shifting column index k with k>=2, win_valid=1 on the next cycle.
- win_last=1 when k = rw_q-1.
- win_valid holds, with win_data stable, until win_ready=1. A window is transferred when win_valid & win_ready.
- Windows per row: rw_q-2. Throughput is 1 window/cycle when win_ready stays high.
- Boundaries:
  - rw_q<3: the sweep still reads all rw_q addresses to release the row, emits no windows, then returns to IDLE.
  - rw_q=0 is treated as 1.
  - full is ignored outside IDLE. A full seen in IDLE the cycle after DRAIN starts a new sweep; there is no idle gap requirement.
  - Counters compare against rw_q, never against the live row_width.

Optional Feature:
- Macro CONV_WINDOW_ZERO_PAD_EN.
- When defined: same-size padding. A zero column is shifted in before column 0 and after column rw_q-1, giving rw_q windows per row. win_last is set on the window whose c1 = rw_q-1. rw_q=1 yields 1 window.
- When undefined: valid-only windows, rw_q-2 per row, as described above.

Decomposition:
- Shared package conv_pkg:
  - WIN_K=3 constant.
  - State typedef {IDLE, READ, DRAIN}.
  - Window element index function (r*3+c).
- Sub-module conv_col_skid: a 1-entry column skid buffer with valid/ready on both sides, instantiated once.

Test Plan:
- row_width=5; rows hold 1..5, 11..15, 21..25; win_ready=1 → 3 windows. First window rows {1,2,3},{11,12,13},{21,22,23}. win_last only on the 3rd window. r_add sequence 0..4, then busy drops.
- Same data; win_ready low for cycles 2-6 of the output → no window lost or duplicated. win_data is stable while stalled, r_en=0 during the stall, and 3 windows arrive in order.
- row_width=3 → exactly 1 window with win_last=1. row_width=2 → addrs 0,1 read, 0 windows, return to IDLE.
- Assert rst on the 2nd window → next cycle win_valid=0, r_en=0, busy=0. full held high after reset → a new sweep starts from r_add=0.
- With CONV_WINDOW_ZERO_PAD_EN, row_width=4 → 4 windows. First window c0 column all zeros. Last window c2 column all zeros, with win_last=1.
- Back-to-back: full stays high across two sweeps → the second sweep starts and its output is contiguous with the first, with no stale columns from the first.
